// File: rtl/bist_pipe_buf.sv
// bist_pipe_buf
// Multi-channel, multi-stage retiming pipeline for BIST memory-access signals.
// It sits between the BIST controller and up to pCH memory wrappers, and adds
// global hold (freeze), flush (kill in-flight accesses) and occupancy reporting.
//
// Optional feature macro: BIST_PIPE_BUF_PARITY_EN
//   When defined, an even-parity bit per channel is computed at S0 and carried
//   with the pattern. buf_par_err is a sticky per-channel mismatch flag at the
//   output stage. When undefined, buf_par_err is tied to 0. The port list is
//   the same in both builds.
//
// Ports:
//   bist_clk, bist_rst_n     clock, async active-low reset
//   bist_hold                freeze all stages (inputs dropped)
//   bist_flush               clear cs/we of every stage at the next edge
//   bist_cs/we/addr/pat      controller access (pattern packed per channel)
//   buf_cs/we/addr/pat       access delayed by pDEPTH cycles
//   buf_busy                 any stage holds a cs bit
//   buf_inflight             number of stages holding a cs bit
//   buf_par_err              sticky per-channel parity error
module bist_pipe_buf #(
    parameter int pDATA_WIDTH = 2,
    parameter int pADDR_WIDTH = 8,
    parameter int pCH         = 1,
    parameter int pDEPTH      = 2,
    parameter int pCNT_WIDTH  = 5
) (
    input  logic                       bist_clk,
    input  logic                       bist_rst_n,
    input  logic                       bist_hold,
    input  logic                       bist_flush,
    input  logic [pCH-1:0]             bist_cs,
    input  logic [pCH-1:0]             bist_we,
    input  logic [pADDR_WIDTH-1:0]     bist_addr,
    input  logic [pCH*pDATA_WIDTH-1:0] bist_pat,
    output logic [pCH-1:0]             buf_cs,
    output logic [pCH-1:0]             buf_we,
    output logic [pADDR_WIDTH-1:0]     buf_addr,
    output logic [pCH*pDATA_WIDTH-1:0] buf_pat,
    output logic                       buf_busy,
    output logic [pCNT_WIDTH-1:0]      buf_inflight,
    output logic [pCH-1:0]             buf_par_err
);

    localparam int PW = pCH * pDATA_WIDTH;

    // Stage registers; index pDEPTH-1 is the output stage.
    logic [pDEPTH-1:0][pCH-1:0]         cs_q,   cs_d,   cs_src;
    logic [pDEPTH-1:0][pCH-1:0]         we_q,   we_d,   we_src;
    logic [pDEPTH-1:0][pADDR_WIDTH-1:0] addr_q, addr_d, addr_src;
    logic [pDEPTH-1:0][PW-1:0]          pat_q,  pat_d,  pat_src;

    // What each stage would capture on a normal shift: S0 takes the inputs,
    // stage i takes stage i-1.
    generate
        if (pDEPTH > 1) begin : g_shift
            assign cs_src   = {cs_q[pDEPTH-2:0],   bist_cs};
            assign we_src   = {we_q[pDEPTH-2:0],   bist_we};
            assign addr_src = {addr_q[pDEPTH-2:0], bist_addr};
            assign pat_src  = {pat_q[pDEPTH-2:0],  bist_pat};
        end else begin : g_single
            assign cs_src   = bist_cs;
            assign we_src   = bist_we;
            assign addr_src = bist_addr;
            assign pat_src  = bist_pat;
        end
    endgenerate

    always_comb begin
        cs_d   = cs_q;
        we_d   = we_q;
        addr_d = addr_q;
        pat_d  = pat_q;
        if (!bist_hold) begin
            cs_d   = cs_src;
            we_d   = we_src;
            addr_d = addr_src;
            pat_d  = pat_src;
        end
        // Flush overrides hold for the control bits only; addr/pat keep
        // following hold so the datapath is not disturbed.
        if (bist_flush) begin
            cs_d = '0;
            we_d = '0;
        end
    end

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            cs_q   <= '0;
            we_q   <= '0;
            addr_q <= '0;
            pat_q  <= '0;
        end else begin
            cs_q   <= cs_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            pat_q  <= pat_d;
        end
    end

    assign buf_cs   = cs_q[pDEPTH-1];
    assign buf_we   = we_q[pDEPTH-1];
    assign buf_addr = addr_q[pDEPTH-1];
    assign buf_pat  = pat_q[pDEPTH-1];
    assign buf_busy = |cs_q;

    // Occupancy counts stages, not channels; we without cs does not count.
    always_comb begin
        buf_inflight = '0;
        for (int i = 0; i < pDEPTH; i++) begin
            if (|cs_q[i]) buf_inflight = buf_inflight + pCNT_WIDTH'(1);
        end
    end

`ifdef BIST_PIPE_BUF_PARITY_EN
    logic [pDEPTH-1:0][pCH-1:0] par_q, par_d, par_src;
    logic [pCH-1:0]             in_par, out_par, err_q, err_d;

    always_comb begin
        in_par  = '0;
        out_par = '0;
        for (int k = 0; k < pCH; k++) begin
            in_par[k]  = ^bist_pat[k*pDATA_WIDTH +: pDATA_WIDTH];
            out_par[k] = ^buf_pat[k*pDATA_WIDTH +: pDATA_WIDTH];
        end
    end

    generate
        if (pDEPTH > 1) begin : g_par_shift
            assign par_src = {par_q[pDEPTH-2:0], in_par};
        end else begin : g_par_single
            assign par_src = in_par;
        end
    endgenerate

    always_comb begin
        par_d = bist_hold ? par_q : par_src;
        // Only accesses actually presented (cs set) can raise an error.
        err_d = err_q | (buf_cs & (out_par ^ par_q[pDEPTH-1]));
        if (bist_flush) err_d = '0;
    end

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            par_q <= '0;
            err_q <= '0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end

    assign buf_par_err = err_q;
`else
    assign buf_par_err = '0;
`endif

endmodule

// File: tb/tb_bist_pipe_buf.sv
module tb_bist_pipe_buf;
    localparam int DW  = 2;
    localparam int AW  = 8;
    localparam int CH  = 2;
    localparam int DEP = 3;
    localparam int CW  = 5;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               hold  = 1'b0;
    logic               flush = 1'b0;
    logic [CH-1:0]      cs    = '0;
    logic [CH-1:0]      we    = '0;
    logic [AW-1:0]      addr  = '0;
    logic [CH*DW-1:0]   pat   = '0;

    logic [CH-1:0]      o_cs, o_we, o_perr;
    logic [AW-1:0]      o_addr;
    logic [CH*DW-1:0]   o_pat;
    logic               o_busy;
    logic [CW-1:0]      o_inf;

    bist_pipe_buf #(
        .pDATA_WIDTH(DW), .pADDR_WIDTH(AW), .pCH(CH), .pDEPTH(DEP), .pCNT_WIDTH(CW)
    ) dut (
        .bist_clk(clk), .bist_rst_n(rst_n), .bist_hold(hold), .bist_flush(flush),
        .bist_cs(cs), .bist_we(we), .bist_addr(addr), .bist_pat(pat),
        .buf_cs(o_cs), .buf_we(o_we), .buf_addr(o_addr), .buf_pat(o_pat),
        .buf_busy(o_busy), .buf_inflight(o_inf), .buf_par_err(o_perr)
    );

    always #5 clk = ~clk;

    // Reference: the pipeline is a fixed-length FIFO of access records.
    // mq[0] is the oldest record (what the outputs show).
    typedef struct {
        logic [CH-1:0]    cs;
        logic [CH-1:0]    we;
        logic [AW-1:0]    addr;
        logic [CH*DW-1:0] pat;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void model_reset();
        ent_t z;
        z.cs = '0; z.we = '0; z.addr = '0; z.pat = '0;
        mq.delete();
        for (int i = 0; i < DEP; i++) mq.push_back(z);
    endfunction

    function automatic void model_step();
        ent_t e;
        if (flush) begin
            for (int i = 0; i < mq.size(); i++) begin
                mq[i].cs = '0;
                mq[i].we = '0;
            end
        end
        if (!hold) begin
            e.cs   = flush ? '0 : cs;
            e.we   = flush ? '0 : we;
            e.addr = addr;
            e.pat  = pat;
            void'(mq.pop_front());
            mq.push_back(e);
        end
    endfunction

    function automatic int model_inflight();
        int n = 0;
        foreach (mq[i]) if (mq[i].cs != '0) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int inf;
        inf = model_inflight();
        chk({tag, "_cs"},   32'(o_cs),   32'(mq[0].cs));
        chk({tag, "_we"},   32'(o_we),   32'(mq[0].we));
        chk({tag, "_addr"}, 32'(o_addr), 32'(mq[0].addr));
        chk({tag, "_pat"},  32'(o_pat),  32'(mq[0].pat));
        chk({tag, "_inf"},  32'(o_inf),  32'(inf));
        chk({tag, "_busy"}, 32'(o_busy), 32'(inf != 0));
        chk({tag, "_perr"}, 32'(o_perr), 32'(0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic [CH-1:0] c, input logic [CH-1:0] w,
                         input logic [AW-1:0] a, input logic [CH*DW-1:0] p,
                         input logic h, input logic f);
        cs = c; we = w; addr = a; pat = p; hold = h; flush = f;
    endtask

    task automatic drive_rand(input bit force_cs);
        drive(force_cs ? CH'($urandom_range(1, 3)) : CH'($urandom_range(0, 3)),
              CH'($urandom), AW'($urandom), (CH*DW)'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drive_idle();
        drive('0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    logic [AW-1:0]    sv_addr;
    logic [CH*DW-1:0] sv_pat;

    initial begin
        model_reset();

        // Reset state, including across clock edges while reset is held.
        #1;
        chk_all("reset");
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_edges");
        #2 rst_n = 1'b1;

        // Single access: visible after exactly DEP edges, inflight 1,1,1,0.
        drive(2'b01, 2'b01, 8'h5A, 4'b1011, 1'b0, 1'b0);
        step("t1");
        chk("t1_inf_a", 32'(o_inf), 32'd1);
        drive_idle();
        step("t1");
        chk("t1_inf_b", 32'(o_inf), 32'd1);
        step("t1");
        chk("t1_inf_c", 32'(o_inf), 32'd1);
        chk("t1_out_addr", 32'(o_addr), 32'h5A);
        chk("t1_out_pat",  32'(o_pat),  32'hB);
        chk("t1_out_cs",   32'(o_cs),   32'h1);
        step("t1");
        chk("t1_inf_d", 32'(o_inf), 32'd0);
        chk("t1_busy_d", 32'(o_busy), 32'd0);

        // Back-to-back stream: inflight saturates at DEP.
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            step("t2");
            if (i >= DEP - 1) chk("t2_inf_full", 32'(o_inf), 32'(DEP));
        end
        drive_idle();
        repeat (DEP) step("t2_drain");

        // Hold for 4 cycles while an access sits in S1.
        drive_rand(1'b1);
        sv_addr = addr;
        sv_pat  = pat;
        step("t3");
        drive_idle();
        step("t3");
        for (int i = 0; i < 4; i++) begin
            drive(CH'($urandom), CH'($urandom), AW'($urandom), (CH*DW)'($urandom), 1'b1, 1'b0);
            step("t3_hold");
            chk("t3_hold_inf", 32'(o_inf), 32'd1);
        end
        drive_idle();
        step("t3");
        chk("t3_late_addr", 32'(o_addr), 32'(sv_addr));
        chk("t3_late_pat",  32'(o_pat),  32'(sv_pat));
        repeat (DEP) step("t3_drain");

        // Flush with three accesses in flight and a new input.
        for (int i = 0; i < DEP; i++) begin
            drive_rand(1'b1);
            step("t4");
        end
        chk("t4_inf_pre", 32'(o_inf), 32'(DEP));
        drive(2'b11, 2'b11, AW'($urandom), (CH*DW)'($urandom), 1'b0, 1'b1);
        step("t4_flush");
        chk("t4_cs0",   32'(o_cs),   32'd0);
        chk("t4_we0",   32'(o_we),   32'd0);
        chk("t4_inf0",  32'(o_inf),  32'd0);
        chk("t4_busy0", 32'(o_busy), 32'd0);
        drive_idle();
        repeat (DEP) step("t4_after");

        // Asynchronous reset between edges mid-stream.
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1);
            step("t5");
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("t5_async");
        #1 rst_n = 1'b1;
        drive_rand(1'b1);
        sv_addr = addr;
        step("t5_post");
        drive_idle();
        step("t5_post");
        step("t5_post");
        chk("t5_lat_addr", 32'(o_addr), 32'(sv_addr));

        // Random mix of traffic, hold and flush.
        for (int i = 0; i < 300; i++) begin
            drive_rand(1'b0);
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bist_pipe_buf.md
Name: bist_pipe_buf

Overview:
- Parametrised multi-channel, multi-stage retiming pipeline for BIST memory-access signals (chip select, write enable, address, pattern).
- Sits between the BIST controller and up to pCH memory wrappers. Covers long routing distances with a configurable number of register stages.
- Adds global hold (freeze), flush (kill in-flight accesses) and in-flight occupancy reporting.
- pDEPTH=1, pCH=1 with hold/flush tied low gives a plain one-cycle register buffer.

Parameters:
- pDATA_WIDTH, 2: pattern width per channel.
- pADDR_WIDTH, 8: shared address width.
- pCH, 1: number of memory channels; minimum 1.
- pDEPTH, 2: pipeline stages (latency in cycles); minimum 1, maximum 16.
- pCNT_WIDTH, 5: occupancy counter width; must satisfy 2^pCNT_WIDTH > pDEPTH.

Ports:
- bist_clk  input  1  clock
- bist_rst_n  input  1  asynchronous active-low reset
- bist_hold  input  1  freeze all stages while high
- bist_flush  input  1  clear cs/we in all stages at next edge
- bist_cs  input  pCH  per-channel chip select
- bist_we  input  pCH  per-channel write enable
- bist_addr  input  pADDR_WIDTH  shared address
- bist_pat  input  pCH*pDATA_WIDTH  per-channel pattern; channel k at bits [k*pDATA_WIDTH +: pDATA_WIDTH]
- buf_cs  output  pCH  delayed chip select
- buf_we  output  pCH  delayed write enable
- buf_addr  output  pADDR_WIDTH  delayed address
- buf_pat  output  pCH*pDATA_WIDTH  delayed pattern
- buf_busy  output  1  high when any stage holds any cs bit
- buf_inflight  output  pCNT_WIDTH  number of stages holding at least one cs bit
- buf_par_err  output  pCH  sticky per-channel parity error (optional feature)

Behaviour:
- Clocking and reset: one clock, bist_clk. Reset is asynchronous and active-low on bist_rst_n.
- Reset values: all stage registers 0. Therefore all outputs are 0: buf_cs, buf_we, buf_addr, buf_pat, buf_busy, buf_inflight, buf_par_err.
- Structure: stages S0..S(pDEPTH-1). S0 captures inputs; stage i captures stage i-1. Outputs are driven directly from S(pDEPTH-1), with no combinational path from input to output.
- Latency: an input sampled at edge n appears on the outputs after edge n+pDEPTH-1, i.e. pDEPTH cycles, provided hold is low throughout.
- Hold (bist_hold=1, bist_flush=0):
  - Every stage keeps its value and inputs are ignored (dropped).
  - Outputs stay stable for the entire hold.
  - The controller must not issue new accesses during hold.
- Flush (bist_flush=1):
  - At the next edge, cs and we of every stage, S0 included, are cleared. The input presented in the flush cycle is discarded.
  - addr/pat shift normally, or hold if bist_hold=1.
  - Flush has priority over hold.
- Occupancy:
  - buf_busy = OR over all stages of (OR of stage cs).
  - buf_inflight = count of stages whose cs vector is non-zero.
  - Both are combinational from stage registers, so they are valid in the same cycle as the stage contents.
- buf_inflight range: 0 to pDEPTH, never wrapping. Example: pDEPTH=16, pCNT_WIDTH=5 reports 16.
- Channel independence: each channel's cs/we/pat travels in lockstep with the shared addr. No cross-channel interaction.
- Reset mid-operation: all in-flight accesses are lost immediately. Outputs go to 0 asynchronously.
- we without cs: passed through unchanged. It is not counted in occupancy.

Optional Feature:
- Macro: BIST_PIPE_BUF_PARITY_EN.
- Defined:
  - S0 computes one even-parity bit per channel over bist_pat and carries it through all stages alongside the pattern.
  - At the output stage, buf_par_err[k] sets when buf_cs[k]=1 and the recomputed parity of channel k pattern differs from the carried bit.
  - The error is sticky until reset or a flush edge clears it. Flush clearing takes priority over a simultaneous set.
  - Parity bits are also cleared by reset and follow hold.
- Not defined: no parity storage; buf_par_err tied to 0. The port list is identical in both builds.

Test Plan:
- pCH=2, pDEPTH=3, hold/flush=0: drive cs=2'b01, we=2'b01, addr=8'h5A, pat=4'b1011 for one cycle -> identical values on outputs exactly 3 cycles later. buf_inflight sequence is 1,1,1 on those cycles, then 0. buf_busy matches.
- Back-to-back accesses on every cycle for 10 cycles with pDEPTH=3 -> outputs replay the input stream delayed by 3. buf_inflight reaches 3 and stays 3 while streaming.
- Access issued, hold asserted for 4 cycles while it sits in S1 -> outputs and buf_inflight are frozen during hold. The access emerges 4 cycles later than nominal with the same addr/pat.
- Three accesses in flight (buf_inflight=3), then one-cycle flush together with a new input cs=2'b11 -> next cycle buf_cs=0, buf_we=0, buf_inflight=0, buf_busy=0. The new input never appears.
- Assert bist_rst_n low asynchronously mid-stream, between clock edges -> all outputs 0 immediately. After release, the first new access appears with nominal latency.
- With BIST_PIPE_BUF_PARITY_EN defined: force one pattern bit of channel 1 in S1 -> buf_par_err=2'b10 when the access reaches the output. It stays set through later clean accesses and clears on the flush edge.
